// File: rtl/uart_led_pkg.sv
// Shared constants for the UART LED command parser.
// Holds the ASCII bytes the frame grammar uses, the parser state encoding
// and the data-mode selector.
package uart_led_pkg;

   localparam logic [7:0] ASC_COMMA = 8'h2C;
   localparam logic [7:0] ASC_COLON = 8'h3A;
   localparam logic [7:0] ASC_CR    = 8'h0D;
   localparam logic [7:0] ASC_0     = 8'h30;
   localparam logic [7:0] ASC_9     = 8'h39;
   localparam logic [7:0] ASC_UA    = 8'h41;
   localparam logic [7:0] ASC_UF    = 8'h46;
   localparam logic [7:0] ASC_LA    = 8'h61;
   localparam logic [7:0] ASC_LF    = 8'h66;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_SEP  = 2'd2,
      ST_DATA = 2'd3
   } state_t;

   typedef enum logic {
      MODE_SEL  = 1'b0,
      MODE_MASK = 1'b1
   } mode_t;

endpackage

// File: rtl/uart_led_ctrl_if.sv
// Byte-stream and status bundle between the UART receiver side and the
// LED command parser.
//   RECEIVE_END  : one-cycle strobe, rxd valid
//   rxd          : received byte
//   SEND_END_cmd : parser enable
//   LED          : LED drive
//   cmd_ok       : pulse on an applied command
//   cmd_err      : pulse on an aborted or rejected command
//   busy         : parser is mid-frame
interface uart_led_ctrl_if #(
   parameter int unsigned LED_W = 8
) ();

   logic             RECEIVE_END;
   logic [7:0]       rxd;
   logic             SEND_END_cmd;
   logic [LED_W-1:0] LED;
   logic             cmd_ok;
   logic             cmd_err;
   logic             busy;

   modport master (
      output RECEIVE_END, rxd, SEND_END_cmd,
      input  LED, cmd_ok, cmd_err, busy
   );

   modport slave (
      input  RECEIVE_END, rxd, SEND_END_cmd,
      output LED, cmd_ok, cmd_err, busy
   );

endinterface

// File: rtl/uart_ascii_decode.sv
// Combinational ASCII digit decoder.
//   rxd      : byte to classify
//   mode     : MODE_SEL accepts decimal only, MODE_MASK also accepts hex letters
//   is_digit : byte is a legal digit for the mode
//   value    : digit value (0 when not a digit)
module uart_ascii_decode
   import uart_led_pkg::*;
(
   input  logic [7:0] rxd,
   input  mode_t      mode,
   output logic       is_digit,
   output logic [3:0] value
);

   always_comb begin
      is_digit = 1'b0;
      value    = 4'd0;
      if (rxd >= ASC_0 && rxd <= ASC_9) begin
         is_digit = 1'b1;
         value    = 4'(rxd - ASC_0);
      end else if (mode == MODE_MASK && rxd >= ASC_UA && rxd <= ASC_UF) begin
         is_digit = 1'b1;
         value    = 4'(rxd - ASC_UA + 8'd10);
      end else if (mode == MODE_MASK && rxd >= ASC_LA && rxd <= ASC_LF) begin
         is_digit = 1'b1;
         value    = 4'(rxd - ASC_LA + 8'd10);
      end
   end

endmodule

// File: rtl/uart_led_ctrl.sv
// UART LED command parser. Parses frames ",<ID>:<digits>CR" and drives LED
// either one-hot (SEL_ID, decimal index) or from a hex mask (MASK_ID).
//   iCLK  : clock, rising edge
//   RST_n : asynchronous active-low reset
//   bus   : byte strobe/enable in, LED and status pulses out
module uart_led_ctrl
   import uart_led_pkg::*;
#(
   parameter int unsigned LED_W       = 8,
   parameter logic [7:0]  SEL_ID      = 8'h32,
   parameter logic [7:0]  MASK_ID     = 8'h33,
   parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
   input  logic            iCLK,
   input  logic            RST_n,
   uart_led_ctrl_if.slave  bus
);

   localparam int unsigned NIB_MAX = (LED_W + 3) / 4;
   localparam int unsigned ACC_W   = (4 * NIB_MAX > 7) ? 4 * NIB_MAX : 7;
   localparam int unsigned CNT_W   = 3;
   localparam int unsigned TO_W    = $clog2(TIMEOUT_CYC);

   state_t             state, state_nxt;
   mode_t              mode, mode_nxt;
   logic [ACC_W-1:0]   acc, acc_nxt;
   logic [CNT_W-1:0]   dcnt, dcnt_nxt;
   logic [TO_W-1:0]    to_cnt, to_nxt;
   logic [LED_W-1:0]   led_q, led_nxt;
   logic               ok_q, ok_nxt;
   logic               err_q, err_nxt;
   logic               busy_q, busy_nxt;

   logic               byte_acc;
   logic               to_hit;
   logic               is_digit;
   logic [3:0]         dig_val;
   logic [CNT_W-1:0]   dig_lim;

   uart_ascii_decode u_dec (
      .rxd      (bus.rxd),
      .mode     (mode),
      .is_digit (is_digit),
      .value    (dig_val)
   );

   assign byte_acc = bus.RECEIVE_END & bus.SEND_END_cmd;
   assign to_hit   = (to_cnt == TO_W'(TIMEOUT_CYC - 1));
   assign dig_lim  = (mode == MODE_SEL) ? CNT_W'(2) : CNT_W'(NIB_MAX);

   // State and output registers
   always_ff @(posedge iCLK or negedge RST_n) begin
      if (!RST_n) begin
         state  <= ST_IDLE;
         mode   <= MODE_SEL;
         acc    <= '0;
         dcnt   <= '0;
         to_cnt <= '0;
         led_q  <= '0;
         ok_q   <= 1'b0;
         err_q  <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         mode   <= mode_nxt;
         acc    <= acc_nxt;
         dcnt   <= dcnt_nxt;
         to_cnt <= to_nxt;
         led_q  <= led_nxt;
         ok_q   <= ok_nxt;
         err_q  <= err_nxt;
         busy_q <= busy_nxt;
      end
   end

   // Frame parser; an accepted byte takes priority over timeout expiry
   always_comb begin
      state_nxt = state;
      mode_nxt  = mode;
      acc_nxt   = acc;
      dcnt_nxt  = dcnt;
      led_nxt   = led_q;
      ok_nxt    = 1'b0;
      err_nxt   = 1'b0;
      to_nxt    = (state == ST_IDLE) ? '0 : to_cnt + TO_W'(1);

      if (byte_acc) begin
         to_nxt = '0;
         unique case (state)
            ST_IDLE: begin
               if (bus.rxd == ASC_COMMA) state_nxt = ST_HDR;
            end
            ST_HDR: begin
               if (bus.rxd == SEL_ID) begin
                  state_nxt = ST_SEP;
                  mode_nxt  = MODE_SEL;
               end else if (bus.rxd == MASK_ID) begin
                  state_nxt = ST_SEP;
                  mode_nxt  = MODE_MASK;
               end else if (bus.rxd != ASC_COMMA) begin
                  state_nxt = ST_IDLE;
                  err_nxt   = 1'b1;
               end
            end
            ST_SEP: begin
               if (bus.rxd == ASC_COLON) begin
                  state_nxt = ST_DATA;
                  acc_nxt   = '0;
                  dcnt_nxt  = '0;
               end else if (bus.rxd == ASC_COMMA) begin
                  state_nxt = ST_HDR;
               end else begin
                  state_nxt = ST_IDLE;
                  err_nxt   = 1'b1;
               end
            end
            ST_DATA: begin
               state_nxt = ST_IDLE;
               if (is_digit) begin
                  if (dcnt == dig_lim) begin
                     err_nxt = 1'b1;
                  end else begin
                     state_nxt = ST_DATA;
                     dcnt_nxt  = dcnt + CNT_W'(1);
                     if (mode == MODE_SEL)
                        acc_nxt = (acc << 3) + (acc << 1) + ACC_W'(dig_val);
                     else
                        acc_nxt = (acc << 4) | ACC_W'(dig_val);
                  end
               end else if (bus.rxd == ASC_CR && dcnt != '0) begin
                  if (mode == MODE_SEL) begin
                     if (acc == '0) begin
                        led_nxt = '0;
                        ok_nxt  = 1'b1;
                     end else if (acc <= ACC_W'(LED_W)) begin
                        led_nxt = LED_W'(1) << (acc - ACC_W'(1));
                        ok_nxt  = 1'b1;
                     end else begin
                        err_nxt = 1'b1;
                     end
                  end else if ((acc >> LED_W) != '0) begin
                     err_nxt = 1'b1;
                  end else begin
                     led_nxt = LED_W'(acc);
                     ok_nxt  = 1'b1;
                  end
               end else begin
                  err_nxt = 1'b1;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end else if (state != ST_IDLE && to_hit) begin
         state_nxt = ST_IDLE;
         err_nxt   = 1'b1;
         to_nxt    = '0;
      end

      busy_nxt = (state_nxt != ST_IDLE);
   end

   assign bus.LED     = led_q;
   assign bus.cmd_ok  = ok_q;
   assign bus.cmd_err = err_q;
   assign bus.busy    = busy_q;

endmodule

// File: tb/tb_uart_led_ctrl.sv
// Scoreboard bench for uart_led_ctrl: two instances (LED_W=8 and LED_W=16,
// TIMEOUT_CYC=100) receive the same byte stream; a frame-level reference
// model predicts each ok/err event, and a negedge monitor checks them.
module tb_uart_led_ctrl;

   typedef struct {
      bit          ok;
      logic [15:0] led;
   } ev_t;

   logic iCLK = 1'b0;
   logic RST_n = 1'b0;
   always #5 iCLK = ~iCLK;

   uart_led_ctrl_if #(.LED_W(8))  bus8  ();
   uart_led_ctrl_if #(.LED_W(16)) bus16 ();

   uart_led_ctrl #(.LED_W(8),  .TIMEOUT_CYC(100)) dut8  (.iCLK(iCLK), .RST_n(RST_n), .bus(bus8));
   uart_led_ctrl #(.LED_W(16), .TIMEOUT_CYC(100)) dut16 (.iCLK(iCLK), .RST_n(RST_n), .bus(bus16));

   int n_chk = 0;
   int n_fail = 0;

   ev_t q0[$];
   ev_t q1[$];
   logic [15:0] cur_led[2];

   // reference model state, per instance
   int m_ph[2];
   int m_md[2];
   int m_acc[2];
   int m_nd[2];
   int m_led[2];

   task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic push_ev(int k, bit ok);
      ev_t e;
      e.ok  = ok;
      e.led = 16'(m_led[k]);
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic model_err(int k);
      push_ev(k, 1'b0);
      m_ph[k] = 0;
   endtask

   function automatic int hexval(logic [7:0] b, int md);
      if (b >= 8'h30 && b <= 8'h39) return int'(b) - 48;
      if (md == 1 && b >= 8'h61 && b <= 8'h66) return int'(b) - 87;
      if (md == 1 && b >= 8'h41 && b <= 8'h46) return int'(b) - 55;
      return -1;
   endfunction

   // Frame-grammar reference: phase 0 waiting for ',', 1 ID, 2 ':', 3 digits
   task automatic model_byte(int k, logic [7:0] b);
      int w, nmax, v;
      w    = (k == 0) ? 8 : 16;
      nmax = (w + 3) / 4;
      v    = hexval(b, m_md[k]);
      case (m_ph[k])
         0: if (b == 8'h2C) m_ph[k] = 1;
         1: begin
            if (b == 8'h32)      begin m_ph[k] = 2; m_md[k] = 0; end
            else if (b == 8'h33) begin m_ph[k] = 2; m_md[k] = 1; end
            else if (b != 8'h2C) model_err(k);
         end
         2: begin
            if (b == 8'h3A)      begin m_ph[k] = 3; m_acc[k] = 0; m_nd[k] = 0; end
            else if (b == 8'h2C) m_ph[k] = 1;
            else                 model_err(k);
         end
         default: begin
            if (v >= 0) begin
               if (m_nd[k] == ((m_md[k] == 1) ? nmax : 2)) model_err(k);
               else begin
                  m_acc[k] = (m_md[k] == 1) ? m_acc[k] * 16 + v : m_acc[k] * 10 + v;
                  m_nd[k]++;
               end
            end else if (b == 8'h0D && m_nd[k] > 0) begin
               m_ph[k] = 0;
               if (m_md[k] == 0) begin
                  if (m_acc[k] == 0)      begin m_led[k] = 0; push_ev(k, 1'b1); end
                  else if (m_acc[k] <= w) begin m_led[k] = 1 << (m_acc[k] - 1); push_ev(k, 1'b1); end
                  else                    push_ev(k, 1'b0);
               end else begin
                  if (m_acc[k] >= (1 << w)) push_ev(k, 1'b0);
                  else begin m_led[k] = m_acc[k]; push_ev(k, 1'b1); end
               end
            end else begin
               model_err(k);
            end
         end
      endcase
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_ph[k] = 0; m_md[k] = 0; m_acc[k] = 0; m_nd[k] = 0; m_led[k] = 0;
      end
   endtask

   task automatic set_in(logic re, logic [7:0] b, logic en);
      bus8.RECEIVE_END  = re; bus8.rxd  = b; bus8.SEND_END_cmd  = en;
      bus16.RECEIVE_END = re; bus16.rxd = b; bus16.SEND_END_cmd = en;
   endtask

   task automatic send_byte(logic [7:0] b, bit en, int gap);
      @(posedge iCLK); #1;
      set_in(1'b1, b, en);
      if (en) begin
         model_byte(0, b);
         model_byte(1, b);
      end
      @(posedge iCLK); #1;
      set_in(1'b0, 8'($urandom), 1'b1);
      repeat (gap) @(posedge iCLK);
   endtask

   // '$' in a frame string stands for CR
   task automatic send_str(string s);
      logic [7:0] c;
      for (int i = 0; i < s.len(); i++) begin
         c = s[i];
         if (c == 8'h24) c = 8'h0D;
         send_byte(c, 1'b1, $urandom_range(0, 2));
      end
   endtask

   // idle long enough for any open frame to time out
   task automatic idle_timeout();
      for (int k = 0; k < 2; k++)
         if (m_ph[k] != 0) model_err(k);
      repeat (120) @(posedge iCLK);
   endtask

   task automatic rand_frame();
      string hexs;
      logic [7:0] f[$];
      int nd, md;
      hexs = "0123456789abcdefABCDEF";
      if ($urandom_range(0, 7) == 0) f.push_back(8'($urandom));
      f.push_back(8'h2C);
      md = $urandom_range(0, 1);
      case ($urandom_range(0, 9))
         0:       f.push_back(8'h2C);
         1:       f.push_back(8'h78);
         default: f.push_back(md == 1 ? 8'h33 : 8'h32);
      endcase
      f.push_back($urandom_range(0, 9) == 0 ? 8'h71 : 8'h3A);
      nd = $urandom_range(0, 5);
      for (int i = 0; i < nd; i++) begin
         if ($urandom_range(0, 15) == 0)      f.push_back(8'h67);
         else if (md == 1)                    f.push_back(hexs[$urandom_range(0, 21)]);
         else if (i == 0)                     f.push_back(8'(8'h30 + $urandom_range(0, 2)));
         else                                 f.push_back(8'(8'h30 + $urandom_range(0, 9)));
      end
      if ($urandom_range(0, 9) != 0) f.push_back(8'h0D);
      foreach (f[i]) send_byte(f[i], $urandom_range(0, 15) != 0, $urandom_range(0, 3));
   endtask

   task automatic mon(int k, logic [15:0] led, logic ok, logic err, logic busy);
      ev_t e;
      string p;
      p = $sformatf("dut%0d", k == 0 ? 8 : 16);
      if (ok || err) begin
         chk({p, " ok_err_exclusive"}, 16'(ok & err), 16'd0);
         if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s unexpected_event: got ok=%b err=%b expected none at %0t", p, ok, err, $time);
         end else begin
            e = (k == 0) ? q0.pop_front() : q1.pop_front();
            chk({p, " ok_flag"}, 16'(ok), 16'(e.ok));
            chk({p, " err_flag"}, 16'(err), 16'(!e.ok));
            chk({p, " led_at_event"}, led, e.led);
            chk({p, " busy_after_event"}, 16'(busy), 16'd0);
            cur_led[k] = e.led;
         end
      end else begin
         chk({p, " led_hold"}, led, cur_led[k]);
      end
   endtask

   always @(negedge iCLK) begin
      if (!RST_n) begin
         cur_led[0] = 16'd0;
         cur_led[1] = 16'd0;
      end else begin
         mon(0, 16'(bus8.LED), bus8.cmd_ok, bus8.cmd_err, bus8.busy);
         mon(1, bus16.LED, bus16.cmd_ok, bus16.cmd_err, bus16.busy);
      end
   end

   task automatic chk_zero(string tag);
      chk({tag, " dut8 LED"},      16'(bus8.LED),      16'd0);
      chk({tag, " dut8 cmd_ok"},   16'(bus8.cmd_ok),   16'd0);
      chk({tag, " dut8 cmd_err"},  16'(bus8.cmd_err),  16'd0);
      chk({tag, " dut8 busy"},     16'(bus8.busy),     16'd0);
      chk({tag, " dut16 LED"},     bus16.LED,          16'd0);
      chk({tag, " dut16 cmd_ok"},  16'(bus16.cmd_ok),  16'd0);
      chk({tag, " dut16 cmd_err"}, 16'(bus16.cmd_err), 16'd0);
      chk({tag, " dut16 busy"},    16'(bus16.busy),    16'd0);
   endtask

   initial begin
      model_reset();
      set_in(1'b0, 8'h00, 1'b1);
      #1;
      chk_zero("reset");
      repeat (3) @(posedge iCLK);
      #2 RST_n = 1'b1;

      send_str(",2:5$");
      send_str(",2:12$");
      send_str(",2:17$");
      send_str(",3:a5$");
      send_str(",3:1a5$");

      send_str(",2:");
      chk("open_frame dut8 busy", 16'(bus8.busy), 16'd1);
      idle_timeout();
      send_str("3$");

      send_str(",2,2:3$");
      send_str(",2:");
      send_byte(8'h37, 1'b0, 1);
      send_str("$");

      send_str(",3:F$");
      send_str(",2:0$");
      send_str(",3:FFFF$");
      send_str(",2:16$");

      send_str(",2:4");
      @(posedge iCLK); #2;
      RST_n = 1'b0;
      #1;
      chk_zero("mid_frame_reset");
      model_reset();
      repeat (3) @(posedge iCLK);
      #2 RST_n = 1'b1;
      send_str(",2:1$");

      for (int i = 0; i < 80; i++) begin
         rand_frame();
         if ($urandom_range(0, 19) == 0) idle_timeout();
      end

      idle_timeout();
      repeat (5) @(posedge iCLK);
      chk("dut8 events_left",  16'(q0.size()), 16'd0);
      chk("dut16 events_left", 16'(q1.size()), 16'd0);
      chk("dut8 final_led",  16'(bus8.LED), 16'(m_led[0]));
      chk("dut16 final_led", bus16.LED,     16'(m_led[1]));
      chk("dut8 final_busy",  16'(bus8.busy),  16'd0);
      chk("dut16 final_busy", 16'(bus16.busy), 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
